// File: rtl/gpio_gcd_pkg.sv
// Shared definitions for the GCD register front-end: register map,
// status bit positions and the launch FSM state encoding.
package gpio_gcd_pkg;

  localparam logic [15:0] ADDR_A1 = 16'h00F8;
  localparam logic [15:0] ADDR_A2 = 16'h00FC;
  localparam logic [15:0] ADDR_W  = 16'h0100;
  localparam logic [15:0] ADDR_S  = 16'h0104;

  localparam int S_RDY     = 0;
  localparam int S_FULL    = 1;
  localparam int S_OVF     = 2;
  localparam int S_BUSY    = 3;
  localparam int S_OVW     = 4;
  localparam int S_CNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/gcd_bus_frontend_strobe_sync.sv
// Brings an asynchronous bus strobe into the clk domain and turns its
// rising edge into a single-cycle event pulse.
module strobe_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic pulse
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic              pulse_q, pulse_d;

  always_comb begin
    sync_d  = {sync_q[STAGES-2:0], strobe};
    prev_d  = sync_q[STAGES-1];
    pulse_d = sync_q[STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/gcd_bus_frontend.sv
// Bus register front-end for the GCD engine: decodes A1/A2/W/S, queues
// operand pairs, launches them over valid/ready and captures results.
module gcd_bus_frontend
  import gpio_gcd_pkg::*;
#(
  parameter int QDEPTH      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  output logic        gcd_req_valid,
  input  logic        gcd_req_ready,
  output logic [31:0] gcd_a,
  output logic [31:0] gcd_b,
  input  logic        gcd_res_valid,
  input  logic [31:0] gcd_res
);

  localparam int AW = $clog2(QDEPTH);
  localparam int PW = AW + 1;

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_sync_q <= 2'b11;
    else       rst_sync_q <= rst_sync_d;
  end

  assign rst = rst_sync_q[1];

  logic rd_ev, wr_ev;

  strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (
    .clk(clk), .rst(rst), .strobe(srd), .pulse(rd_ev)
  );

  strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_wr (
    .clk(clk), .rst(rst), .strobe(swr), .pulse(wr_ev)
  );

  logic [31:0] a1_q, a1_d, a2_q, a2_d, w_q, w_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rdy_q, rdy_d, ovf_q, ovf_d, ovw_q, ovw_d;
  logic [31:0] qa_q [QDEPTH];
  logic [31:0] qb_q [QDEPTH];
  logic [31:0] qa_d [QDEPTH];
  logic [31:0] qb_d [QDEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  fsm_state_e  state_q, state_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] ga_q, ga_d, gb_q, gb_d;

  logic [PW-1:0] count;
  logic          empty, full, busy;
  logic          pop, push_req, push_ok, drop, w_upd;
  logic          rd_w, rd_s;
  logic [31:0]   pop_a, pop_b, s_now;

  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    empty    = (count == '0);
    full     = (count == PW'(QDEPTH));
    busy     = (state_q != IDLE) || !empty;
    pop_a    = qa_q[rd_ptr_q[AW-1:0]];
    pop_b    = qb_q[rd_ptr_q[AW-1:0]];
    pop      = (state_q == IDLE) && !empty;
    push_req = wr_ev && (saddress == ADDR_A2);
    // A pop in the same cycle frees a slot, so a full queue still accepts.
    push_ok  = push_req && (!full || pop);
    drop     = push_req && !push_ok;
    rd_w     = rd_ev && (saddress == ADDR_W);
    rd_s     = rd_ev && (saddress == ADDR_S);

    a1_d = a1_q;
    a2_d = a2_q;
    if (wr_ev && saddress == ADDR_A1) a1_d = sdata_in;
    if (push_req)                     a2_d = sdata_in;

    qa_d = qa_q;
    qb_d = qb_q;
    if (push_ok) begin
      qa_d[wr_ptr_q[AW-1:0]] = a1_q;
      qb_d[wr_ptr_q[AW-1:0]] = sdata_in;
    end
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop);

    state_d     = state_q;
    req_valid_d = req_valid_q;
    ga_d        = ga_q;
    gb_d        = gb_q;
    w_d         = w_q;
    w_upd       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          if (pop_a == '0 || pop_b == '0) begin
            w_d   = pop_a | pop_b;
            w_upd = 1'b1;
          end else begin
            ga_d        = pop_a;
            gb_d        = pop_b;
            req_valid_d = 1'b1;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        if (gcd_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (gcd_res_valid) begin
          w_d     = gcd_res;
          w_upd   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        req_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    // A new result wins over a concurrent W read so it is never lost.
    rdy_d = rdy_q;
    if (rd_w)  rdy_d = 1'b0;
    if (w_upd) rdy_d = 1'b1;
    ovw_d = ovw_q | (w_upd & rdy_q & ~rd_w);
    ovf_d = ovf_q;
    if (rd_s) ovf_d = 1'b0;
    if (drop) ovf_d = 1'b1;

    s_now                   = '0;
    s_now[S_RDY]            = rdy_q;
    s_now[S_FULL]           = full;
    s_now[S_OVF]            = ovf_q;
    s_now[S_BUSY]           = busy;
    s_now[S_OVW]            = ovw_q;
    s_now[S_CNT_LSB +: 8]   = 8'(count);

    rdata_d = rdata_q;
    if (rd_ev) begin
      case (saddress)
        ADDR_A1: rdata_d = a1_d;
        ADDR_A2: rdata_d = a2_d;
        ADDR_W:  rdata_d = w_q;
        ADDR_S:  rdata_d = s_now;
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1_q        <= '0;
      a2_q        <= '0;
      w_q         <= '0;
      rdata_q     <= '0;
      rdy_q       <= 1'b0;
      ovf_q       <= 1'b0;
      ovw_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      ga_q        <= '0;
      gb_q        <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        qa_q[i] <= '0;
        qb_q[i] <= '0;
      end
    end else begin
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      w_q         <= w_d;
      rdata_q     <= rdata_d;
      rdy_q       <= rdy_d;
      ovf_q       <= ovf_d;
      ovw_q       <= ovw_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      ga_q        <= ga_d;
      gb_q        <= gb_d;
      qa_q        <= qa_d;
      qb_q        <= qb_d;
    end
  end

  assign sdata_out     = rdata_q;
  assign gcd_req_valid = req_valid_q;
  assign gcd_a         = ga_q;
  assign gcd_b         = gb_q;

endmodule
